// File: rtl/eql_cam_seq.sv
// eql_cam_seq: sequential CAM. Stores up to DEPTH reference words and scans
// them one entry per cycle, starting at index 0, to find the lowest index that
// matches a search key.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               invalidate all entries (taken only while wr_rdy=1)
//   wr_vld/wr_rdy     write request / accept (wr_idx, wr_dat)
//   srch_vld/srch_rdy search request / accept (srch_key [, srch_msk])
//   rsp_vld/rsp_rdy   result handshake (rsp_hit, rsp_idx)
//
// Optional feature: define EQL_CAM_SEQ_MASK_EN to add srch_msk, a per-bit
// don't-care mask latched with the key. Undefined: exact equality.
module eql_cam_seq #(
  parameter  int WIDTH     = 4,
  parameter  int DEPTH     = 8,
  localparam int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_vld,
  output logic                 wr_rdy,
  input  logic [DEPTH_LOG-1:0] wr_idx,
  input  logic [WIDTH-1:0]     wr_dat,
  input  logic                 srch_vld,
  output logic                 srch_rdy,
  input  logic [WIDTH-1:0]     srch_key,
`ifdef EQL_CAM_SEQ_MASK_EN
  input  logic [WIDTH-1:0]     srch_msk,
`endif
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic                 rsp_hit,
  output logic [DEPTH_LOG-1:0] rsp_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t               state_q, state_d;
  logic [DEPTH_LOG-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     key_q, key_d;
  logic [WIDTH-1:0]     msk_q, msk_d;
  logic                 hit_q, hit_d;
  logic [DEPTH_LOG-1:0] idx_q, idx_d;
  logic                 vld_q;

  logic [WIDTH-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;

  logic                 idx_ok;
  logic                 wr_acc;
  logic                 clr_acc;
  logic [WIDTH-1:0]     diff;
  logic                 match;
  logic                 last;

  // The table is only writable while idle, so it is frozen during a lookup.
  assign wr_rdy   = (state_q == IDLE);
  assign srch_rdy = (state_q == IDLE);

  // Out-of-range write indices can only occur when DEPTH is not a power of 2.
  generate
    if (DEPTH == (1 << DEPTH_LOG)) begin : g_pow2
      assign idx_ok = 1'b1;
    end else begin : g_npow2
      assign idx_ok = ({1'b0, wr_idx} < (DEPTH_LOG+1)'(DEPTH));
    end
  endgenerate

  assign wr_acc  = wr_vld & wr_rdy & idx_ok;
  assign clr_acc = clr & wr_rdy;

  // Clear first, then write: a write coinciding with clr leaves its entry valid.
  always_comb begin
    valid_d = valid_q;
    if (clr_acc) valid_d = '0;
    if (wr_acc)  valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Data array carries no reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (wr_acc) data_q[wr_idx] <= wr_dat;
  end

  // Masked-off bits are don't-care; with the mask unused it stays zero.
  assign diff  = (data_q[cnt_q] ^ key_q) & ~msk_q;
  assign match = valid_q[cnt_q] & ~(|diff);
  assign last  = (cnt_q == DEPTH_LOG'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    msk_d   = msk_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (srch_vld) begin
          key_d   = srch_key;
`ifdef EQL_CAM_SEQ_MASK_EN
          msk_d   = srch_msk;
`else
          msk_d   = '0;
`endif
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          idx_d   = cnt_q;
          state_d = RESP;
        end else if (last) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + DEPTH_LOG'(1);
        end
      end
      RESP: begin
        // hit/idx registers are untouched here, so the result holds under stall.
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      msk_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      msk_q   <= msk_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      // Registered copy of (state==RESP) so rsp_vld is a flop output.
      vld_q   <= (state_d == RESP);
    end
  end

  assign rsp_vld = vld_q;
  assign rsp_hit = hit_q;
  assign rsp_idx = idx_q;

endmodule

// File: tb/tb_eql_cam_seq.sv
module tb_eql_cam_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_vld;
  logic       wr_rdy;
  logic [2:0] wr_idx;
  logic [3:0] wr_dat;
  logic       srch_vld;
  logic       srch_rdy;
  logic [3:0] srch_key;
  logic [3:0] srch_msk;
  logic       rsp_vld;
  logic       rsp_rdy;
  logic       rsp_hit;
  logic [2:0] rsp_idx;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {expected hit, expected idx}
  logic [3:0] sb [$];

  always #5 clk = ~clk;

  eql_cam_seq #(.WIDTH(4), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_vld   (wr_vld),
    .wr_rdy   (wr_rdy),
    .wr_idx   (wr_idx),
    .wr_dat   (wr_dat),
    .srch_vld (srch_vld),
    .srch_rdy (srch_rdy),
    .srch_key (srch_key),
`ifdef EQL_CAM_SEQ_MASK_EN
    .srch_msk (srch_msk),
`endif
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_hit  (rsp_hit),
    .rsp_idx  (rsp_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic wr(input logic [2:0] idx, input logic [3:0] dat, input logic do_clr);
    wr_vld = 1'b1;
    wr_idx = idx;
    wr_dat = dat;
    clr    = do_clr;
    @(posedge clk); #1;
    wr_vld = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic search(input string tag, input logic [3:0] key, input logic [3:0] msk,
                        input logic hit, input logic [2:0] idx, input int lat, input int hold);
    int n;
    logic [3:0] exp;
    sb.push_back({hit, idx});
    check({tag, ":srch_rdy_pre"}, srch_rdy, 1);
    srch_key = key;
    srch_msk = msk;
    srch_vld = 1'b1;
    rsp_rdy  = (hold == 0);
    @(posedge clk); #1;
    srch_vld = 1'b0;
    n = 0;
    check({tag, ":wr_rdy_scan"}, wr_rdy, 0);
    while (!rsp_vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ":latency"}, n, lat);
    exp = sb.pop_front();
    check({tag, ":hit"}, rsp_hit, exp[3]);
    check({tag, ":idx"}, rsp_idx, exp[2:0]);
    for (int h = 0; h < hold; h++) begin
      // These requests must all be refused while the response is stalled.
      wr_vld   = 1'b1;
      wr_idx   = 3'd0;
      wr_dat   = key;
      srch_vld = 1'b1;
      @(posedge clk); #1;
      check({tag, ":hold_vld"}, rsp_vld, 1);
      check({tag, ":hold_hit"}, rsp_hit, exp[3]);
      check({tag, ":hold_idx"}, rsp_idx, exp[2:0]);
      check({tag, ":hold_wr_rdy"}, wr_rdy, 0);
      check({tag, ":hold_srch_rdy"}, srch_rdy, 0);
    end
    wr_vld   = 1'b0;
    srch_vld = 1'b0;
    rsp_rdy  = 1'b1;
    @(posedge clk); #1;
    check({tag, ":done_vld"}, rsp_vld, 0);
    check({tag, ":done_srch_rdy"}, srch_rdy, 1);
    check({tag, ":done_wr_rdy"}, wr_rdy, 1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_vld = 1'b0; wr_idx = '0; wr_dat = '0;
    srch_vld = 1'b0; srch_key = '0; srch_msk = '0; rsp_rdy = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_wr_rdy", wr_rdy, 1);
    check("rst_srch_rdy", srch_rdy, 1);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_hit", rsp_hit, 0);
    check("rst_rsp_idx", rsp_idx, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty table: full scan, miss.
    search("miss_empty", 4'h3, 4'h0, 1'b0, 3'd0, 8, 0);

    // Lowest matching index wins.
    wr(3'd2, 4'hA, 1'b0);
    wr(3'd5, 4'hA, 1'b0);
    search("hit_idx2", 4'hA, 4'h0, 1'b1, 3'd2, 3, 0);

    // Last-entry hit takes the full scan.
    wr(3'd7, 4'hC, 1'b0);
    search("hit_idx7", 4'hC, 4'h0, 1'b1, 3'd7, 8, 0);

    // Stalled response; the refused write to idx0 must not show up afterwards.
    search("hold", 4'hA, 4'h0, 1'b1, 3'd2, 3, 4);
    search("after_hold", 4'hA, 4'h0, 1'b1, 3'd2, 3, 0);

    // Write+search accepted in the same idle cycle: scan sees the new entry.
    srch_key = 4'h9; srch_msk = 4'h0; srch_vld = 1'b1; rsp_rdy = 1'b1;
    wr_vld = 1'b1; wr_idx = 3'd0; wr_dat = 4'h9;
    sb.push_back({1'b1, 3'd0});
    @(posedge clk); #1;
    srch_vld = 1'b0; wr_vld = 1'b0;
    begin
      int n;
      logic [3:0] exp;
      n = 0;
      while (!rsp_vld && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      exp = sb.pop_front();
      check("same_cycle:latency", n, 1);
      check("same_cycle:hit", rsp_hit, exp[3]);
      check("same_cycle:idx", rsp_idx, exp[2:0]);
    end
    @(posedge clk); #1;

    // clr with a same-cycle write: clear first, then write.
    wr(3'd7, 4'h5, 1'b0);
    wr(3'd1, 4'h5, 1'b1);
    search("clr_wr", 4'h5, 4'h0, 1'b1, 3'd1, 2, 0);
    do_clr();
    search("clr_only", 4'h5, 4'h0, 1'b0, 3'd0, 8, 0);
    search("clr_only_a", 4'hA, 4'h0, 1'b0, 3'd0, 8, 0);

    // Reset during a scan discards the lookup and clears the table.
    wr(3'd3, 4'h6, 1'b0);
    srch_key = 4'hE; srch_vld = 1'b1;
    @(posedge clk); #1;
    srch_vld = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_scan_vld", rsp_vld, 0);
    check("rst_scan_srch_rdy", srch_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_scan_vld2", rsp_vld, 0);
    search("after_rst", 4'h6, 4'h0, 1'b0, 3'd0, 8, 0);

`ifdef EQL_CAM_SEQ_MASK_EN
    wr(3'd4, 4'b1010, 1'b0);
    search("mask_hit", 4'b1111, 4'b0101, 1'b1, 3'd4, 5, 0);
    search("mask_zero", 4'b1111, 4'b0000, 1'b0, 3'd0, 8, 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/eql_cam_seq.md
# eql_cam_seq

Sequential content-addressable lookup table built around the equality comparator. It stores up to DEPTH reference words through a write port. Each accepted search key is compared against one stored entry per clock cycle, starting at index 0. It returns hit/miss and the lowest matching index through a valid/ready response channel. It is the storage and lookup counterpart to the combinational comparator, used wherever a key must be matched against a programmable set of references at low area cost.

## Interface
- WIDTH, 4, bit width of stored references and search keys
- DEPTH, 8, number of entries, ≥2; DEPTH_LOG = $clog2(DEPTH) (local)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset (one clock; reset is asynchronous and active-high)
- clr  input  1  invalidate all entries (accepted only when wr_rdy=1)
- wr_vld  input  1  write request
- wr_rdy  output  1  write/clr accepted; equals (state==IDLE)
- wr_idx  input  DEPTH_LOG  entry index to write
- wr_dat  input  WIDTH  reference value to store
- srch_vld  input  1  search request
- srch_rdy  output  1  search accepted; equals (state==IDLE)
- srch_key  input  WIDTH  value to look up
- rsp_vld  output  1  result valid
- rsp_rdy  input  1  result consumed
- rsp_hit  output  1  1 = an entry matched
- rsp_idx  output  DEPTH_LOG  lowest matching index; 0 on miss

## Operation
- Storage: DEPTH × WIDTH data array, plus DEPTH entry-valid bits. Data is not reset. Valid bits reset to 0.
- Write at edge with wr_vld & wr_rdy: data[wr_idx] <= wr_dat and valid[wr_idx] <= 1. wr_idx ≥ DEPTH is ignored.
- clr & wr_rdy: all valid bits <= 0. If it coincides with an accepted write, the written entry ends valid: clear first, then write.
- FSM states IDLE, SCAN, RESP:
  - IDLE: on srch_vld & srch_rdy, latch key, set cnt <= 0, go to SCAN.
  - SCAN: match = valid[cnt] & (data[cnt] == key).
    - If match: rsp_hit <= 1, rsp_idx <= cnt, go to RESP.
    - Else if cnt == DEPTH-1: rsp_hit <= 0, rsp_idx <= 0, go to RESP.
    - Else: cnt <= cnt+1.
  - RESP: rsp_vld = 1. On rsp_rdy, go to IDLE. rsp_hit and rsp_idx are held stable while rsp_vld & ~rsp_rdy.
- Simultaneous write and search accepted in the same IDLE cycle: the scan sees the newly written entry.
- Writes and clr are stalled (wr_rdy=0) in SCAN and RESP, so the table is frozen during a lookup.
- Reset mid-scan or mid-response: FSM returns to IDLE and the pending result is discarded.

## Timing
- Reset values: wr_rdy=1, srch_rdy=1, rsp_vld=0, rsp_hit=0, rsp_idx=0, all entries invalid.
- Search accepted at edge E0, first match at index k: rsp_vld rises after edge E0+k+1.
- Miss: rsp_vld rises after edge E0+DEPTH.
- srch_rdy and wr_rdy return high the cycle after the edge where rsp_vld & rsp_rdy. No back-to-back search throughput; minimum search period is k+3 cycles.
- rsp_vld, rsp_hit and rsp_idx are registered outputs. srch_rdy and wr_rdy are decoded directly from state registers.
- No combinational path from any input to any output.

## Configuration
- EQL_CAM_SEQ_MASK_EN defined:
  - Adds input srch_msk [WIDTH], latched together with srch_key.
  - Match rule becomes valid[cnt] & (((data[cnt] ^ key) & ~msk) == 0); a set mask bit is don't-care.
- Undefined: port absent, exact equality. Behaviour is identical to the defined case with msk = 0.

## Test plan
WIDTH=4, DEPTH=8 for all scenarios.
- Reset, then search key 4'h3 with rsp_rdy=1 -> rsp_vld 8 cycles after accept, rsp_hit=0, rsp_idx=0.
- Write idx2=4'hA and idx5=4'hA, search 4'hA -> rsp_hit=1, rsp_idx=2, rsp_vld 3 cycles after accept.
- Hold rsp_rdy=0 for 4 cycles during a response -> rsp_vld, rsp_hit and rsp_idx stable; wr_vld ignored (wr_rdy=0); a search with srch_vld=1 is not accepted.
- Write idx7=4'h5, then clr with a same-cycle write idx1=4'h5, then search 4'h5 -> hit, idx=1. A second search after clr alone -> miss.
- Assert rst during SCAN -> next cycle rsp_vld=0, srch_rdy=1. A following search of a previously written key misses.
- With EQL_CAM_SEQ_MASK_EN: store idx4=4'b1010, search key 4'b1111 with msk 4'b0101 -> hit, idx=4. Same search with msk=0 -> miss.
